// File: rtl/dram_responder_if.sv
// rtl/dram_responder_if.sv - core-side and backend-side signals of the DRAM responder
interface dram_responder_if;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic        w_dram_le;
  logic        w_dram_we_t;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;
  logic        w_dram_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output w_dram_addr, w_dram_wdata, w_dram_le, w_dram_we_t, w_dram_ctrl,
    input  w_dram_busy, w_dram_odata, w_dram_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

  modport slave (
    input  w_dram_addr, w_dram_wdata, w_dram_le, w_dram_we_t, w_dram_ctrl,
    output w_dram_busy, w_dram_odata, w_dram_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );
endinterface

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - single-outstanding DRAM load/store responder with timeout
// DRAM_RESP_MISALIGN_EN: split word-crossing accesses into two backend words instead of rejecting them.
module dram_responder #(
  parameter int TIMEOUT = 1023
) (
  input logic            CLK,
  input logic            RST_X,
  dram_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);
`ifdef DRAM_RESP_MISALIGN_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
    return ((sz == 2'd1) && (off == 2'd3)) || (sz[1] && (off != 2'd0));
  endfunction

  function automatic logic [31:0] load_extend(input logic [63:0] raw, input logic [1:0] off,
                                              input logic [2:0] c);
    logic [31:0] sh;
    sh = 32'(raw >> {off, 3'b000});
    case (c[1:0])
      2'd0:    return {{24{sh[7] & ~c[2]}}, sh[7:0]};
      2'd1:    return {{16{sh[15] & ~c[2]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_t                state;
  logic [1:0]            off_q;
  logic [2:0]            ctrl_q;
  logic                  we_q;
  logic                  err_pend;
  logic                  tmo_q;
  logic [9:0]            wait_cnt;
  logic [32*SPAN-1:0]    asm_q;
`ifdef DRAM_RESP_MISALIGN_EN
  logic                  split_q;
  logic [31:0]           nxt_addr_q;
  logic [3:0]            nxt_be_q;
  logic [31:0]           nxt_wdata_q;
`else
  logic                  rej_q;
`endif

  logic                  strobe;
  logic [1:0]            in_off;
  logic                  in_cross;
  logic                  wait_expired;
  logic [4*SPAN-1:0]     in_span;
  logic [32*SPAN-1:0]    in_lanes;

  assign strobe       = bus.w_dram_le | bus.w_dram_we_t;
  assign in_off       = bus.w_dram_addr[1:0];
  assign in_cross     = crosses(bus.w_dram_ctrl[1:0], in_off);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  // Byte enables and lanes for both words; the upper half only exists when splitting.
  assign in_span      = (4*SPAN)'(size_mask(bus.w_dram_ctrl[1:0])) << in_off;
  assign in_lanes     = (32*SPAN)'(bus.w_dram_wdata) << {in_off, 3'b000};

  // Combinational so the strobe cycle itself already reports busy.
  assign bus.w_dram_busy = RST_X & ((state != IDLE) | strobe);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state            <= IDLE;
      off_q            <= '0;
      ctrl_q           <= '0;
      we_q             <= 1'b0;
      err_pend         <= 1'b0;
      tmo_q            <= 1'b0;
      wait_cnt         <= '0;
      asm_q            <= '0;
`ifdef DRAM_RESP_MISALIGN_EN
      split_q          <= 1'b0;
      nxt_addr_q       <= '0;
      nxt_be_q         <= '0;
      nxt_wdata_q      <= '0;
`else
      rej_q            <= 1'b0;
`endif
      bus.w_dram_odata <= '0;
      bus.w_dram_err   <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_be       <= '0;
    end else begin
      bus.w_dram_err <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            off_q    <= in_off;
            ctrl_q   <= bus.w_dram_ctrl;
            we_q     <= bus.w_dram_we_t;
            err_pend <= bus.w_dram_le & bus.w_dram_we_t;
            tmo_q    <= 1'b0;
            wait_cnt <= '0;
`ifdef DRAM_RESP_MISALIGN_EN
            split_q     <= in_cross;
            nxt_addr_q  <= {bus.w_dram_addr[31:2], 2'b00} + 32'd4;
            nxt_be_q    <= bus.w_dram_we_t ? in_span[7:4] : 4'b1111;
            nxt_wdata_q <= bus.w_dram_we_t ? in_lanes[63:32] : 32'd0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.w_dram_we_t;
            bus.mem_addr  <= {bus.w_dram_addr[31:2], 2'b00};
            bus.mem_be    <= bus.w_dram_we_t ? in_span[3:0] : 4'b1111;
            bus.mem_wdata <= bus.w_dram_we_t ? in_lanes[31:0] : 32'd0;
            state         <= ACC0;
`else
            rej_q <= in_cross;
            if (in_cross) begin
              bus.w_dram_err <= 1'b1;
              state          <= FIN;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.w_dram_we_t;
              bus.mem_addr  <= {bus.w_dram_addr[31:2], 2'b00};
              bus.mem_be    <= bus.w_dram_we_t ? in_span : 4'b1111;
              bus.mem_wdata <= bus.w_dram_we_t ? in_lanes : 32'd0;
              state         <= ACC0;
            end
`endif
          end
        end

        ACC0: begin
          if (bus.mem_ack) begin
            asm_q[31:0] <= bus.mem_rdata;
            bus.mem_req <= 1'b0;
            wait_cnt    <= '0;
`ifdef DRAM_RESP_MISALIGN_EN
            if (split_q) begin
              bus.mem_addr  <= nxt_addr_q;
              bus.mem_be    <= nxt_be_q;
              bus.mem_wdata <= nxt_wdata_q;
              state         <= ACC1;
            end else begin
              bus.w_dram_err <= err_pend;
              state          <= FIN;
            end
`else
            bus.w_dram_err <= err_pend;
            state          <= FIN;
`endif
          end else if (wait_expired) begin
            bus.mem_req    <= 1'b0;
            tmo_q          <= 1'b1;
            bus.w_dram_err <= 1'b1;
            state          <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end

`ifdef DRAM_RESP_MISALIGN_EN
        ACC1: begin
          // First cycle here is the mandatory request gap after the ACC0 ack.
          if (!bus.mem_req) begin
            bus.mem_req <= 1'b1;
          end else if (bus.mem_ack) begin
            asm_q[63:32]   <= bus.mem_rdata;
            bus.mem_req    <= 1'b0;
            bus.w_dram_err <= err_pend;
            state          <= FIN;
          end else if (wait_expired) begin
            bus.mem_req    <= 1'b0;
            tmo_q          <= 1'b1;
            bus.w_dram_err <= 1'b1;
            state          <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
`endif

        FIN: begin
          if (!we_q) begin
`ifdef DRAM_RESP_MISALIGN_EN
            bus.w_dram_odata <= tmo_q ? 32'hFFFF_FFFF : load_extend(64'(asm_q), off_q, ctrl_q);
`else
            bus.w_dram_odata <= tmo_q ? 32'hFFFF_FFFF :
                                rej_q ? 32'd0 : load_extend(64'(asm_q), off_q, ctrl_q);
`endif
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed self-checking bench for dram_responder
module tb_dram_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_responder_if bus ();
  dram_responder #(.TIMEOUT(8)) dut (.CLK(clk), .RST_X(rst_n), .bus(bus.slave));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Backend model state: main process writes the knobs, responder writes the log.
  int          ack_delay = 0;
  logic        stale_ack = 1'b0;
  logic [31:0] rd_q [2];
  int          log_n = 0;
  logic [31:0] log_addr [16];
  logic [31:0] log_wdata [16];
  logic [3:0]  log_be [16];
  logic        log_we [16];
  int          bn, rn, en, base;

  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (stale_ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBADB_AD00;
      end else if (bus.mem_req && ack_delay >= 0) begin
        if (wcnt == ack_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd_q[bus.mem_addr[2]];
          log_addr[log_n % 16] = bus.mem_addr;
          log_wdata[log_n % 16] = bus.mem_wdata;
          log_be[log_n % 16] = bus.mem_be;
          log_we[log_n % 16] = bus.mem_we;
          log_n++;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] c,
                        input logic le, input logic we,
                        output int busy_n, output int req_n, output int err_n);
    bit done;
    done = 0;
    busy_n = 0; req_n = 0; err_n = 0;
    @(negedge clk);
    bus.w_dram_addr = a; bus.w_dram_wdata = wd; bus.w_dram_ctrl = c;
    bus.w_dram_le = le; bus.w_dram_we_t = we;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (bus.w_dram_busy) busy_n++; else done = 1;
      if (bus.mem_req) req_n++;
      if (bus.w_dram_err) err_n++;
      if (!done) begin
        @(negedge clk);
        bus.w_dram_le = 1'b0; bus.w_dram_we_t = 1'b0;
      end
    end
    total_cnt++;
    if (!done) $display("FAIL access_done: busy still high after 60 cycles, want 0");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.w_dram_addr = 0; bus.w_dram_wdata = 0; bus.w_dram_ctrl = 0;
    bus.w_dram_le = 0; bus.w_dram_we_t = 0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (bus.w_dram_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.w_dram_busy); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'd0) $display("FAIL rst_odata: got %h want 0", bus.w_dram_odata); else pass_cnt++;
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.mem_req); else pass_cnt++;
    total_cnt++; if (bus.w_dram_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.w_dram_err); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'd0) $display("FAIL rst_be: got %b want 0", bus.mem_be); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_load();
    ack_delay = 0; rd_q[0] = 32'hDEAD_BEEF; rd_q[1] = 32'hDEAD_BEEF;
    base = log_n;
    access(32'h100, 32'h0, 3'd2, 1'b1, 1'b0, bn, rn, en);
    total_cnt++; if (bn !== 3) $display("FAIL al_busy_cycles: got %0d want 3", bn); else pass_cnt++;
    total_cnt++; if (rn !== 1) $display("FAIL al_req_cycles: got %0d want 1", rn); else pass_cnt++;
    total_cnt++; if (en !== 0) $display("FAIL al_err: got %0d want 0", en); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'hDEAD_BEEF) $display("FAIL al_odata: got %h want deadbeef", bus.w_dram_odata); else pass_cnt++;
    total_cnt++; if (log_be[base % 16] !== 4'b1111) $display("FAIL al_be: got %b want 1111", log_be[base % 16]); else pass_cnt++;
    total_cnt++; if (log_addr[base % 16] !== 32'h100) $display("FAIL al_addr: got %h want 00000100", log_addr[base % 16]); else pass_cnt++;
    total_cnt++; if (log_we[base % 16] !== 1'b0) $display("FAIL al_we: got %b want 0", log_we[base % 16]); else pass_cnt++;
  endtask

  task automatic test_extend();
    logic [31:0] addrs [5];
    logic [2:0]  ctrls [5];
    logic [31:0] exp  [5];
    addrs = '{32'h103, 32'h103, 32'h102, 32'h101, 32'h100};
    ctrls = '{3'd0, 3'd4, 3'd1, 3'd0, 3'd3};
    exp   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_0034, 32'h8012_3456};
    ack_delay = 0; rd_q[0] = 32'h8012_3456; rd_q[1] = 32'h8012_3456;
    for (int i = 0; i < 5; i++) begin
      access(addrs[i], 32'h0, ctrls[i], 1'b1, 1'b0, bn, rn, en);
      total_cnt++;
      if (bus.w_dram_odata !== exp[i]) $display("FAIL ext_%0d: got %h want %h", i, bus.w_dram_odata, exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_half_store();
    ack_delay = 1;
    base = log_n;
    access(32'h102, 32'h0000_1234, 3'd1, 1'b0, 1'b1, bn, rn, en);
    total_cnt++; if (log_n - base !== 1) $display("FAIL hs_writes: got %0d want 1", log_n - base); else pass_cnt++;
    total_cnt++; if (log_be[base % 16] !== 4'b1100) $display("FAIL hs_be: got %b want 1100", log_be[base % 16]); else pass_cnt++;
    total_cnt++; if (log_wdata[base % 16][31:16] !== 16'h1234) $display("FAIL hs_wdata: got %h want 1234", log_wdata[base % 16][31:16]); else pass_cnt++;
    total_cnt++; if (log_we[base % 16] !== 1'b1) $display("FAIL hs_we: got %b want 1", log_we[base % 16]); else pass_cnt++;
    total_cnt++; if (bn !== 4) $display("FAIL hs_busy_cycles: got %0d want 4", bn); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'h8012_3456) $display("FAIL hs_odata_kept: got %h want 80123456", bus.w_dram_odata); else pass_cnt++;
  endtask

  task automatic test_conflict();
    ack_delay = 0;
    base = log_n;
    access(32'h104, 32'h0000_0055, 3'd2, 1'b1, 1'b1, bn, rn, en);
    total_cnt++; if (log_we[base % 16] !== 1'b1) $display("FAIL cf_we: got %b want 1", log_we[base % 16]); else pass_cnt++;
    total_cnt++; if (log_wdata[base % 16] !== 32'h55) $display("FAIL cf_wdata: got %h want 00000055", log_wdata[base % 16]); else pass_cnt++;
    total_cnt++; if (en !== 1) $display("FAIL cf_err: got %0d want 1", en); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'h8012_3456) $display("FAIL cf_odata_kept: got %h want 80123456", bus.w_dram_odata); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    ack_delay = 0;
    base = log_n;
    access(32'h1FE, 32'hAABB_CCDD, 3'd2, 1'b0, 1'b1, bn, rn, en);
`ifdef DRAM_RESP_MISALIGN_EN
    total_cnt++; if (log_n - base !== 2) $display("FAIL ms_writes: got %0d want 2", log_n - base); else pass_cnt++;
    total_cnt++; if (log_addr[base % 16] !== 32'h1FC) $display("FAIL ms_addr0: got %h want 000001fc", log_addr[base % 16]); else pass_cnt++;
    total_cnt++; if (log_be[base % 16] !== 4'b1100) $display("FAIL ms_be0: got %b want 1100", log_be[base % 16]); else pass_cnt++;
    total_cnt++; if (log_wdata[base % 16] !== 32'hCCDD_0000) $display("FAIL ms_wd0: got %h want ccdd0000", log_wdata[base % 16]); else pass_cnt++;
    total_cnt++; if (log_addr[(base + 1) % 16] !== 32'h200) $display("FAIL ms_addr1: got %h want 00000200", log_addr[(base + 1) % 16]); else pass_cnt++;
    total_cnt++; if (log_be[(base + 1) % 16] !== 4'b0011) $display("FAIL ms_be1: got %b want 0011", log_be[(base + 1) % 16]); else pass_cnt++;
    total_cnt++; if (log_wdata[(base + 1) % 16] !== 32'h0000_AABB) $display("FAIL ms_wd1: got %h want 0000aabb", log_wdata[(base + 1) % 16]); else pass_cnt++;
    total_cnt++; if (en !== 0) $display("FAIL ms_err: got %0d want 0", en); else pass_cnt++;
    rd_q[1] = 32'h1122_3344; rd_q[0] = 32'h5566_7788;
    base = log_n;
    access(32'hFFFF_FFFF, 32'h0, 3'd1, 1'b1, 1'b0, bn, rn, en);
    total_cnt++; if (log_addr[(base + 1) % 16] !== 32'h0) $display("FAIL ms_wrap_addr: got %h want 00000000", log_addr[(base + 1) % 16]); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'hFFFF_8811) $display("FAIL ms_wrap_odata: got %h want ffff8811", bus.w_dram_odata); else pass_cnt++;
`else
    total_cnt++; if (rn !== 0) $display("FAIL ms_req_cycles: got %0d want 0", rn); else pass_cnt++;
    total_cnt++; if (log_n - base !== 0) $display("FAIL ms_writes: got %0d want 0", log_n - base); else pass_cnt++;
    total_cnt++; if (en !== 1) $display("FAIL ms_err: got %0d want 1", en); else pass_cnt++;
    total_cnt++; if (bn !== 2) $display("FAIL ms_busy_cycles: got %0d want 2", bn); else pass_cnt++;
    access(32'h103, 32'h0, 3'd1, 1'b1, 1'b0, bn, rn, en);
    total_cnt++; if (bus.w_dram_odata !== 32'd0) $display("FAIL ms_load_odata: got %h want 0", bus.w_dram_odata); else pass_cnt++;
    total_cnt++; if (en !== 1) $display("FAIL ms_load_err: got %0d want 1", en); else pass_cnt++;
`endif
  endtask

  task automatic test_timeout();
    ack_delay = -1;
    access(32'h200, 32'h0, 3'd2, 1'b1, 1'b0, bn, rn, en);
    total_cnt++; if (rn !== 8) $display("FAIL to_req_cycles: got %0d want 8", rn); else pass_cnt++;
    total_cnt++; if (en !== 1) $display("FAIL to_err: got %0d want 1", en); else pass_cnt++;
    total_cnt++; if (bn !== 10) $display("FAIL to_busy_cycles: got %0d want 10", bn); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'hFFFF_FFFF) $display("FAIL to_odata: got %h want ffffffff", bus.w_dram_odata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ack_delay = -1;
    @(negedge clk);
    bus.w_dram_addr = 32'h300; bus.w_dram_ctrl = 3'd2; bus.w_dram_le = 1'b1;
    @(negedge clk);
    bus.w_dram_le = 1'b0;
    #1;
    total_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL rm_req_before: got %b want 1", bus.mem_req); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rm_req_async: got %b want 0", bus.mem_req); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'd0) $display("FAIL rm_odata_clr: got %h want 0", bus.w_dram_odata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1 stale_ack = 1'b1;
    @(negedge clk);
    #1 stale_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (bus.w_dram_busy !== 1'b0) $display("FAIL rm_idle: busy got %b want 0", bus.w_dram_busy); else pass_cnt++;
    total_cnt++; if (bus.w_dram_odata !== 32'd0) $display("FAIL rm_stale_ack: odata got %h want 0", bus.w_dram_odata); else pass_cnt++;
    ack_delay = 0; rd_q[0] = 32'hCAFE_F00D; rd_q[1] = 32'hCAFE_F00D;
    access(32'h100, 32'h0, 3'd2, 1'b1, 1'b0, bn, rn, en);
    total_cnt++; if (bus.w_dram_odata !== 32'hCAFE_F00D) $display("FAIL rm_recover: got %h want cafef00d", bus.w_dram_odata); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_extend();
    test_half_store();
    test_conflict();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
